// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl
//   Multiplexed 8-digit 7-segment scan controller. Time-shares one segment bus
//   and BCD-to-7-segment converter across eight digit rows, with a blanked
//   dead time at the start of every slot, frame-coherent brightness PWM and
//   leading-zero blanking. Frame period is fixed at 8 * 2^SLOT_LOG2 clocks.
//
// Parameters
//   SLOT_LOG2    log2 of clocks per digit slot (>= 6)
//   DEAD_CYCLES  dark clocks at the start of each slot (1 .. 2^(SLOT_LOG2-4)-1)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   en           scan enable; low returns the scanner to idle at slot 0
//   digits       eight BCD digits, digit k = digits[4k+3:4k], digit 0 = row 0
//   dp_mask      decimal point request per digit
//   lzb          leading-zero blanking enable
//   brightness   on-time level, 0 = dimmest, 15 = full
//   digit        BCD code of the current slot (to the converter)
//   dp           decimal point of the current slot
//   fnd_row      one-hot active-high row select, zero = dark
//   frame_start  one-cycle pulse at phase 0 of slot 0
module fnd_scan_ctrl #(
  parameter int unsigned SLOT_LOG2   = 12,
  parameter int unsigned DEAD_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] digits,
  input  logic [7:0]  dp_mask,
  input  logic        lzb,
  input  logic [3:0]  brightness,
  output logic [3:0]  digit,
  output logic        dp,
  output logic [7:0]  fnd_row,
  output logic        frame_start
);

  typedef enum logic [1:0] {IDLE, DEAD, ON, OFF} state_t;

  localparam logic [SLOT_LOG2-1:0] P_LAST    = '1;
  localparam logic [SLOT_LOG2-1:0] DEAD_LAST = SLOT_LOG2'(DEAD_CYCLES - 1);

  state_t               state, state_n;
  logic [SLOT_LOG2-1:0] p, p_n, p_inc;
  logic [2:0]           idx, idx_n;
  logic [31:0]          digits_q;
  logic [7:0]           dp_q;
  logic [3:0]           brightness_q;
  logic [7:0]           blank_q, blank_n;
  logic                 snap;
  logic                 slot_start;
  logic                 run;

  // A digit is blanked only if it and every more significant digit are zero
  // with no decimal point; digit 0 always stays lit.
  always_comb begin
    blank_n = '0;
    run     = lzb;
    for (int unsigned k = 0; k < 7; k++) begin
      run = run && (digits[4*(7-k) +: 4] == 4'd0) && !dp_mask[7-k];
      blank_n[7-k] = run;
    end
  end

  assign p_inc = p + 1'b1;

  always_comb begin
    state_n    = state;
    p_n        = p;
    idx_n      = idx;
    snap       = 1'b0;
    slot_start = 1'b0;
    if (state == IDLE) begin
      p_n   = '0;
      idx_n = '0;
      if (en) begin
        state_n    = DEAD;
        snap       = 1'b1;
        slot_start = 1'b1;
      end
    end else if (!en) begin
      state_n = IDLE;
      p_n     = '0;
      idx_n   = '0;
    end else if (p == P_LAST) begin
      state_n    = DEAD;
      p_n        = '0;
      idx_n      = idx + 1'b1;
      slot_start = 1'b1;
      snap       = (idx == 3'd7);
    end else begin
      p_n = p_inc;
      unique case (state)
        DEAD: if (p == DEAD_LAST) state_n = blank_q[idx] ? OFF : ON;
        // The state reflects the phase being entered, so the row drops on
        // the first phase whose upper nibble exceeds the brightness level.
        ON:   state_n = (p_inc[SLOT_LOG2-1 -: 4] <= brightness_q) ? ON : OFF;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      p            <= '0;
      idx          <= '0;
      digits_q     <= '0;
      dp_q         <= '0;
      brightness_q <= '0;
      blank_q      <= '0;
      digit        <= '0;
      dp           <= 1'b0;
      fnd_row      <= '0;
      frame_start  <= 1'b0;
    end else begin
      state       <= state_n;
      p           <= p_n;
      idx         <= idx_n;
      frame_start <= snap;
      if (snap) begin
        digits_q     <= digits;
        dp_q         <= dp_mask;
        brightness_q <= brightness;
        blank_q      <= blank_n;
      end
      // Slot 0 of a new frame must show the freshly snapshotted inputs, not
      // the shadow registers being loaded on the same edge.
      if (slot_start) begin
        digit <= snap ? digits[3:0] : digits_q[{idx_n, 2'b00} +: 4];
        dp    <= snap ? dp_mask[0]  : dp_q[idx_n];
      end
      fnd_row <= (state_n == ON) ? (8'b1 << idx_n) : '0;
    end
  end

endmodule
